// File: rtl/key_scan_sequencer.sv
// ---------------------------------------------------------------------------
// key_scan_sequencer
//
// Turns raw PS/2 set-2 scancode bytes into a queue of make codes for the
// keypress-to-character translator. Break sequences (0xF0 ..) and the
// extended prefix (0xE0 ..) are consumed here. Only up/down arrow survive
// the extended set, remapped to 0x05/0x06. A prefix that is left waiting
// too long is abandoned.
//
// Optional feature macro: TYPEMATIC_EN
//   defined   : every make code is queued, including auto-repeats
//   undefined : a make code equal to the currently held key is suppressed
//
// Parameters
//   DEPTH          pending-key FIFO depth (power of 2, 2..16)
//   TIMEOUT_CYCLES idle cycles after which a pending prefix is dropped
//
// Ports
//   clk_in            sole clock, rising edge
//   rst_n_in          synchronous active-low reset
//   scancode_in       raw scancode byte
//   scancode_valid_in one-cycle strobe qualifying scancode_in
//   keypress_out      FIFO head (0x00 when empty)
//   key_valid_out     keypress_out holds an unconsumed entry
//   key_ready_in      consumer takes keypress_out this cycle
//   overflow_out      one-cycle pulse when a key is dropped on a full FIFO
// ---------------------------------------------------------------------------
module key_scan_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] scancode_in,
  input  logic       scancode_valid_in,
  output logic [7:0] keypress_out,
  output logic       key_valid_out,
  input  logic       key_ready_in,
  output logic       overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t            state, state_next;
  logic [TO_W-1:0]   idle_cnt, idle_cnt_next;

  logic              cand_set;
  logic [7:0]        cand_set_code;
  logic              clear_held;

  logic              cand_valid;
  logic [7:0]        cand_code;
  logic              held_valid;
  logic [7:0]        held_code;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full, pop, push, drop, suppress;

  // Decoder: prefix tracking, candidate generation, release detection and
  // the prefix-abandon timer. Any accepted byte restarts the timer.
  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    cand_set      = 1'b0;
    cand_set_code = 8'h00;
    clear_held    = 1'b0;
    if (scancode_valid_in) begin
      idle_cnt_next = '0;
      case (state)
        IDLE: begin
          if (scancode_in == 8'hE0) begin
            state_next = EXT;
          end else if (scancode_in == 8'hF0) begin
            state_next = BRK;
          end else begin
            cand_set      = 1'b1;
            cand_set_code = scancode_in;
          end
        end
        EXT: begin
          if (scancode_in == 8'hF0) begin
            state_next = EXT_BRK;
          end else begin
            state_next = IDLE;
            if (scancode_in == 8'h75) begin
              cand_set      = 1'b1;
              cand_set_code = 8'h05;
            end else if (scancode_in == 8'h72) begin
              cand_set      = 1'b1;
              cand_set_code = 8'h06;
            end
          end
        end
        BRK: begin
          state_next = IDLE;
          clear_held = held_valid && (held_code == scancode_in);
        end
        EXT_BRK: begin
          state_next = IDLE;
          clear_held = held_valid &&
                       (((scancode_in == 8'h75) && (held_code == 8'h05)) ||
                        ((scancode_in == 8'h72) && (held_code == 8'h06)));
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_next    = IDLE;
        idle_cnt_next = '0;
      end else begin
        idle_cnt_next = idle_cnt + TO_W'(1);
      end
    end
  end

  // Repeat suppression compares against the key currently held down.
`ifdef TYPEMATIC_EN
  assign suppress = 1'b0;
`else
  assign suppress = held_valid && (held_code == cand_code);
`endif

  // A full FIFO still accepts a candidate when the head leaves this cycle.
  assign full          = (count == CNT_W'(DEPTH));
  assign key_valid_out = (count != '0);
  assign pop           = key_valid_out && key_ready_in;
  assign push          = cand_valid && !suppress && (!full || pop);
  assign drop          = cand_valid && !suppress && full && !pop;
  assign keypress_out  = key_valid_out ? mem[rd_ptr] : 8'h00;

  // Control state. The candidate is registered so it enters the FIFO one
  // cycle after its strobe. A held-key load wins over a release clear.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      idle_cnt     <= '0;
      cand_valid   <= 1'b0;
      cand_code    <= 8'h00;
      held_valid   <= 1'b0;
      held_code    <= 8'h00;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      state        <= state_next;
      idle_cnt     <= idle_cnt_next;
      cand_valid   <= cand_set;
      cand_code    <= cand_set_code;
      overflow_out <= drop;
      if (cand_valid && (push || suppress)) begin
        held_valid <= 1'b1;
        held_code  <= cand_code;
      end else if (clear_held) begin
        held_valid <= 1'b0;
        held_code  <= 8'h00;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage needs no reset; count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= cand_code;
  end

endmodule
